// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the hazard/forwarding unit: forward-select codes, FSM states
// and the shadow-pipeline entry carried through EX, MEM and WB.
package hazard_forward_unit_pkg;

    // Shadow entries hold register indices at this width; narrower indices are zero-extended.
    localparam int MAX_ADDR_W = 8;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hazState_t;

    typedef struct packed {
        logic                  valid;
        logic                  regWrite;
        logic                  memToReg;
        logic [MAX_ADDR_W-1:0] dst;
        logic [MAX_ADDR_W-1:0] rs;
        logic [MAX_ADDR_W-1:0] rt;
    } shadowEntry_t;

endpackage

// File: rtl/hazard_forward_unit_haz_match.sv
// Dependency comparator: does a consumer register read depend on a producer entry?
// Register 0 never creates a dependency.
module haz_match
    import hazard_forward_unit_pkg::*;
(
    input  shadowEntry_t          producer,
    input  logic [MAX_ADDR_W-1:0] consumerIdx,
    input  logic                  useBit,
    output logic                  match
);

    assign match = producer.valid && producer.regWrite && useBit &&
                   (consumerIdx != '0) && (producer.dst == consumerIdx);

endmodule

// File: rtl/hazard_forward_unit.sv
// Stall, bubble, flush and forwarding control for a 5-stage MIPS-style pipeline.
// Define HAZ_PERF_CNT_EN to add saturating stall_count/flush_count outputs.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_reg_write,
    input  logic                  id_mem_to_reg,
    input  logic                  id_is_branch,
    input  logic                  branch_taken,
    output logic                  stall_pc,
    output logic                  stall_if_id,
    output logic                  bubble_ex,
    output logic                  flush_if_id,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  fwd_br_a,
    output logic                  fwd_br_b,
    output logic [REG_ADDR_W-1:0] ex_dst,
    output logic [REG_ADDR_W-1:0] mem_dst,
    output logic [REG_ADDR_W-1:0] wb_dst
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
`endif
);

    localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

    hazState_t    state, stateNext;
    logic [2:0]   cnt, cntNext;
    shadowEntry_t idEntry, exEntry, memEntry, wbEntry;
    logic [MAX_ADDR_W-1:0] rsIdx, rtIdx;
    logic         useRs, useRt;
    logic         exRsM, exRtM, memRsM, memRtM;
    logic         loadUse, branchHaz, stall;
    logic [1:0]   fwdANext, fwdBNext;

    always_comb begin
        rsIdx          = MAX_ADDR_W'(id_rs);
        rtIdx          = MAX_ADDR_W'(id_rt);
        useRs          = id_valid & id_uses_rs;
        useRt          = id_valid & id_uses_rt;
        idEntry        = '0;
        idEntry.valid    = id_valid;
        idEntry.regWrite = id_reg_write;
        idEntry.memToReg = id_mem_to_reg;
        idEntry.dst      = MAX_ADDR_W'(id_dst);
        idEntry.rs       = rsIdx;
        idEntry.rt       = rtIdx;
    end

    haz_match uExRs  (.producer(exEntry),  .consumerIdx(rsIdx), .useBit(useRs), .match(exRsM));
    haz_match uExRt  (.producer(exEntry),  .consumerIdx(rtIdx), .useBit(useRt), .match(exRtM));
    haz_match uMemRs (.producer(memEntry), .consumerIdx(rsIdx), .useBit(useRs), .match(memRsM));
    haz_match uMemRt (.producer(memEntry), .consumerIdx(rtIdx), .useBit(useRt), .match(memRtM));

    // The comparator sits in ID, so it cannot see an ALU result still in EX or a load still in MEM.
    assign loadUse   = exEntry.memToReg & (exRsM | exRtM);
    assign branchHaz = id_valid & id_is_branch &
                       ((exRsM | exRtM) | (memEntry.memToReg & (memRsM | memRtM)));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            RUN: begin
                if (loadUse) begin
                    cntNext = LAT_M1;
                    if (LAT_M1 != 3'd0) stateNext = LU_STALL;
                end
            end
            LU_STALL: begin
                cntNext = cnt - 3'd1;
                if (cnt <= 3'd1) begin
                    cntNext   = 3'd0;
                    stateNext = RUN;
                end
            end
            default: begin
                stateNext = RUN;
                cntNext   = 3'd0;
            end
        endcase
    end

    always_comb begin
        stall       = (state == LU_STALL) | loadUse | branchHaz;
        stall_pc    = stall;
        stall_if_id = stall;
        bubble_ex   = stall;
        flush_if_id = id_valid & id_is_branch & branch_taken & ~stall;
        fwd_br_a    = memRsM & ~memEntry.memToReg & ~stall;
        fwd_br_b    = memRtM & ~memEntry.memToReg & ~stall;
    end

    // At the ID->EX edge, today's EX becomes tomorrow's MEM and today's MEM becomes tomorrow's WB.
    always_comb begin
        fwdANext = FWD_REG;
        fwdBNext = FWD_REG;
        if (!stall) begin
            if (exRsM)       fwdANext = FWD_MEM;
            else if (memRsM) fwdANext = FWD_WB;
            if (exRtM)       fwdBNext = FWD_MEM;
            else if (memRtM) fwdBNext = FWD_WB;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            exEntry   <= '0;
            memEntry  <= '0;
            wbEntry   <= '0;
            fwd_a_sel <= FWD_REG;
            fwd_b_sel <= FWD_REG;
        end else begin
            exEntry   <= bubble_ex ? '0 : idEntry;
            memEntry  <= exEntry;
            wbEntry   <= memEntry;
            fwd_a_sel <= fwdANext;
            fwd_b_sel <= fwdBNext;
        end
    end

    assign ex_dst  = exEntry.dst[REG_ADDR_W-1:0];
    assign mem_dst = memEntry.dst[REG_ADDR_W-1:0];
    assign wb_dst  = wbEntry.dst[REG_ADDR_W-1:0];

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_pc && (stall_count != '1))    stall_count <= stall_count + 1'b1;
            if (flush_if_id && (flush_count != '1)) flush_count <= flush_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: two instances (LOAD_LAT=1 and 3) share one stimulus stream.
// Counter checks are compiled in when HAZ_PERF_CNT_EN is defined.
module tb_hazard_forward_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       idValid, idUsesRs, idUsesRt, idRegWrite, idMemToReg, idIsBranch, branchTaken;
    logic [4:0] idRs, idRt, idDst;

    logic       l1StallPc, l1StallIfId, l1BubbleEx, l1Flush, l1FwdBrA, l1FwdBrB;
    logic [1:0] l1FwdA, l1FwdB;
    logic [4:0] l1ExDst, l1MemDst, l1WbDst;
    logic       l3StallPc, l3StallIfId, l3BubbleEx, l3Flush, l3FwdBrA, l3FwdBrB;
    logic [1:0] l3FwdA, l3FwdB;
    logic [4:0] l3ExDst, l3MemDst, l3WbDst;
`ifdef HAZ_PERF_CNT_EN
    logic [3:0] l1StallCount, l1FlushCount, l3StallCount, l3FlushCount;
`endif

    int vectorCount = 0;
    int missCount   = 0;
    int stallCycles;

    always #5 clock = ~clock;

    hazard_forward_unit #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(4)) dutL1 (
        .clock(clock), .reset(reset), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
        .id_uses_rs(idUsesRs), .id_uses_rt(idUsesRt), .id_dst(idDst),
        .id_reg_write(idRegWrite), .id_mem_to_reg(idMemToReg), .id_is_branch(idIsBranch),
        .branch_taken(branchTaken), .stall_pc(l1StallPc), .stall_if_id(l1StallIfId),
        .bubble_ex(l1BubbleEx), .flush_if_id(l1Flush), .fwd_a_sel(l1FwdA), .fwd_b_sel(l1FwdB),
        .fwd_br_a(l1FwdBrA), .fwd_br_b(l1FwdBrB), .ex_dst(l1ExDst), .mem_dst(l1MemDst),
        .wb_dst(l1WbDst)
`ifdef HAZ_PERF_CNT_EN
        , .stall_count(l1StallCount), .flush_count(l1FlushCount)
`endif
    );

    hazard_forward_unit #(.REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(4)) dutL3 (
        .clock(clock), .reset(reset), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
        .id_uses_rs(idUsesRs), .id_uses_rt(idUsesRt), .id_dst(idDst),
        .id_reg_write(idRegWrite), .id_mem_to_reg(idMemToReg), .id_is_branch(idIsBranch),
        .branch_taken(branchTaken), .stall_pc(l3StallPc), .stall_if_id(l3StallIfId),
        .bubble_ex(l3BubbleEx), .flush_if_id(l3Flush), .fwd_a_sel(l3FwdA), .fwd_b_sel(l3FwdB),
        .fwd_br_a(l3FwdBrA), .fwd_br_b(l3FwdBrB), .ex_dst(l3ExDst), .mem_dst(l3MemDst),
        .wb_dst(l3WbDst)
`ifdef HAZ_PERF_CNT_EN
        , .stall_count(l3StallCount), .flush_count(l3FlushCount)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic uRs, input logic uRt, input logic [4:0] dst,
                                 input logic rw, input logic m2r, input logic br, input logic tk);
        idValid = v;  idRs = rs;  idRt = rt;  idUsesRs = uRs;  idUsesRt = uRt;
        idDst = dst;  idRegWrite = rw;  idMemToReg = m2r;  idIsBranch = br;  branchTaken = tk;
        #1;
    endtask

    task automatic issueAlu(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt);
        applyStimulus(1'b1, rs, rt, 1'b1, 1'b1, dst, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic issueLw(input logic [4:0] dst, input logic [4:0] base);
        applyStimulus(1'b1, base, dst, 1'b1, 1'b0, dst, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic issueBeq(input logic [4:0] rs, input logic [4:0] rt, input logic tk);
        applyStimulus(1'b1, rs, rt, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, tk);
    endtask

    task automatic issueNop();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Safety net so a wedged run still reports instead of hanging.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        issueNop();
        step(2);
        checkOutput("rstStall",  l1StallPc,   0);
        checkOutput("rstBubble", l1BubbleEx,  0);
        checkOutput("rstFlush",  l1Flush,     0);
        checkOutput("rstFwdA",   l1FwdA,      0);
        checkOutput("rstExDst",  l1ExDst,     0);
        reset = 1'b1;

        // ALU result forwarded from MEM, then from WB with one instruction between
        issueAlu(5'd3, 5'd1, 5'd2);  step(1);
        issueAlu(5'd4, 5'd3, 5'd1);
        checkOutput("aluNoStall", l1StallPc, 0);
        step(1);
        issueNop();
        checkOutput("fwdAMem",  l1FwdA,   1);
        checkOutput("fwdBReg",  l1FwdB,   0);
        checkOutput("exDst4",   l1ExDst,  4);
        checkOutput("memDst3",  l1MemDst, 3);
        issueAlu(5'd8,  5'd1, 5'd2);  step(1);
        issueAlu(5'd10, 5'd1, 5'd2);  step(1);
        issueAlu(5'd11, 5'd1, 5'd8);  step(1);
        issueNop();
        checkOutput("fwdBWb",  l1FwdB,  2);
        checkOutput("fwdAReg", l1FwdA,  0);
        checkOutput("wbDst8",  l1WbDst, 8);
        step(3);

        // Load-use with one bubble
        issueLw(5'd5, 5'd1);  step(1);
        issueAlu(5'd6, 5'd5, 5'd2);
        checkOutput("luStallPc",  l1StallPc,   1);
        checkOutput("luStallIf",  l1StallIfId, 1);
        checkOutput("luBubble",   l1BubbleEx,  1);
        step(1);
        checkOutput("luReleased", l1StallPc, 0);
        checkOutput("luExBubble", l1ExDst,   0);
        checkOutput("luMemLw",    l1MemDst,  5);
        step(1);
        issueNop();
        checkOutput("luFwdWb", l1FwdA, 2);
        step(4);

        // Load-use with three bubbles, counted with a bounded loop
        issueLw(5'd5, 5'd1);  step(1);
        issueAlu(5'd6, 5'd5, 5'd2);
        stallCycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (!l3StallPc) break;
            stallCycles++;
            step(1);
        end
        checkOutput("lat3Stalls", stallCycles, 3);
        step(1);
        issueNop();
        checkOutput("lat3FwdReg", l3FwdA,  0);
        checkOutput("lat3ExDst",  l3ExDst, 6);
        step(4);

        // Branch on an ALU result still in EX: one stall, then comparator forward and flush
        issueAlu(5'd7, 5'd1, 5'd2);  step(1);
        issueBeq(5'd7, 5'd0, 1'b1);
        checkOutput("brStall",     l1StallPc, 1);
        checkOutput("brBubble",    l1BubbleEx, 1);
        checkOutput("brNoFlush",   l1Flush,   0);
        checkOutput("brNoFwdYet",  l1FwdBrA,  0);
        step(1);
        checkOutput("brGo",    l1StallPc, 0);
        checkOutput("brFwdA",  l1FwdBrA,  1);
        checkOutput("brFwdB0", l1FwdBrB,  0);
        checkOutput("brFlush", l1Flush,   1);
        step(1);
        issueNop();
        checkOutput("brFlushOnce", l1Flush, 0);

        // Branch on a load sitting in MEM also stalls and is never forwarded
        issueLw(5'd9, 5'd1);  step(1);
        issueNop();           step(1);
        issueBeq(5'd9, 5'd1, 1'b0);
        checkOutput("brLdMemStall", l1StallPc, 1);
        checkOutput("brLdMemFwd",   l1FwdBrA,  0);
        step(1);
        checkOutput("brLdWbGo",  l1StallPc, 0);
        checkOutput("brLdWbFwd", l1FwdBrA,  0);
        issueNop();
        step(3);

        // Register 0 never forwards or stalls
        issueAlu(5'd0, 5'd1, 5'd2);  step(1);
        issueAlu(5'd12, 5'd0, 5'd0);
        checkOutput("r0NoStall", l1StallPc, 0);
        step(1);
        issueNop();
        checkOutput("r0FwdA", l1FwdA, 0);
        checkOutput("r0FwdB", l1FwdB, 0);
        issueLw(5'd0, 5'd1);  step(1);
        issueAlu(5'd13, 5'd0, 5'd0);
        checkOutput("r0LoadNoStall", l1StallPc, 0);
        step(1);

        // An invalid ID slot never stalls or flushes
        issueLw(5'd5, 5'd1);  step(1);
        applyStimulus(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("invNoStall", l1StallPc, 0);
        checkOutput("invNoFlush", l1Flush,   0);
        issueNop();
        step(4);

        // Reset during the second cycle of a three-cycle load-use stall
        issueLw(5'd5, 5'd1);  step(1);
        issueAlu(5'd6, 5'd5, 5'd2);
        checkOutput("rstLuCyc1", l3StallPc, 1);
        step(1);
        checkOutput("rstLuCyc2", l3StallPc, 1);
        reset = 1'b0;
        step(1);
        checkOutput("rstAbortStall",  l3StallPc,   0);
        checkOutput("rstAbortIf",     l3StallIfId, 0);
        checkOutput("rstAbortBubble", l3BubbleEx,  0);
        checkOutput("rstAbortExDst",  l3ExDst,     0);
        checkOutput("rstAbortMemDst", l3MemDst,    0);
        checkOutput("rstAbortWbDst",  l3WbDst,     0);
        reset = 1'b1;
        step(1);
        checkOutput("rstRunNoStall", l3StallPc, 0);
        issueNop();
        step(4);

`ifdef HAZ_PERF_CNT_EN
        // Counters saturate at 15 with CNT_W=4
        checkOutput("cntStallZero", l1StallCount, 0);
        for (int i = 0; i < 20; i++) begin
            issueLw(5'd5, 5'd1);  step(1);
            issueAlu(5'd6, 5'd5, 5'd2);  step(2);
        end
        issueNop();
        checkOutput("cntStallSat", l1StallCount, 15);
        issueBeq(5'd1, 5'd2, 1'b1);  step(1);
        issueNop();                  step(1);
        issueBeq(5'd1, 5'd2, 1'b1);  step(1);
        issueNop();
        checkOutput("cntFlush2", l1FlushCount, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
